// File: rtl/key_led_seq_pkg.sv
// -----------------------------------------------------------------------------
// key_led_seq_pkg
// Shared types and constants for the key/LED sequencer:
//   - mode_t         : LED display mode (TOGGLE, ONEHOT, BINARY; encoding 3 unused)
//   - KEY_*          : role of each key input bit
//   - N_TOGGLE_LEDS  : width of the LED group inverted in TOGGLE mode
//   - next_mode()    : mode-advance order TOGGLE -> ONEHOT -> BINARY -> TOGGLE
// -----------------------------------------------------------------------------
package key_led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'd0,
        MODE_ONEHOT = 2'd1,
        MODE_BINARY = 2'd2
    } mode_t;

    localparam int KEY_STEP  = 0;
    localparam int KEY_MODE  = 1;
    localparam int KEY_CLEAR = 2;
    localparam int KEY_AUTO  = 3;

    localparam int N_TOGGLE_LEDS = 3;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_TOGGLE: return MODE_ONEHOT;
            MODE_ONEHOT: return MODE_BINARY;
            default:     return MODE_TOGGLE;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// One push-button channel: 2-FF synchronizer, debounce counter and a registered
// single-cycle press pulse on each accepted 0->1 transition.
// Ports:
//   clk      : system clock
//   rst      : asynchronous reset, active low
//   i_key    : raw button level, asynchronous to clk, 1 = pressed
//   o_level  : debounced level
//   o_press  : one-cycle pulse after the debounced level rises
// Parameter:
//   debounce_cycles : consecutive stable synced cycles before a new level is taken
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int debounce_cycles = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_level,
    output logic o_press
);

    localparam int CW = (debounce_cycles > 1) ? $clog2(debounce_cycles) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(debounce_cycles - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_q;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others; the synchronizer chain depends on it.
            r_sync1   <= i_key;
            r_sync2   <= r_sync1;
            r_level_q <= r_level;
            r_press   <= r_level & ~r_level_q;

            // Count only while the synced input disagrees with the accepted
            // level; any return to agreement (bounce) restarts the count.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == C_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + C_ONE;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/key_led_sequencer.sv
// -----------------------------------------------------------------------------
// key_led_sequencer
// Debounces the board keys and uses the press events to drive a mode FSM and
// step counter that sequence the LED bank.
// Ports:
//   clk   : system clock
//   rst   : asynchronous reset, active low
//   key   : raw buttons (1 = pressed); [0] step, [1] mode advance, [2] clear,
//           [3] auto-step hold (only with KEY_LED_SEQ_AUTO_STEP_EN)
//   led   : registered LED drive
//   mode  : current mode (0 TOGGLE, 1 ONEHOT, 2 BINARY)
//   count : current step counter
// Build option:
//   KEY_LED_SEQ_AUTO_STEP_EN : when defined, holding key[3] issues a step every
//                              auto_period_cycles; otherwise key[3] is ignored.
// -----------------------------------------------------------------------------
module key_led_sequencer
    import key_led_seq_pkg::*;
#(
    parameter int w_key              = 4,
    parameter int w_led              = 8,
    parameter int debounce_cycles    = 500000,
    parameter int auto_period_cycles = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [w_key-1:0] key,
    output logic [w_led-1:0] led,
    output logic [1:0]       mode,
    output logic [w_led-1:0] count
);

    localparam logic [w_led-1:0] C_ONE        = w_led'(1);
    localparam logic [w_led-1:0] C_ONEHOT_MAX = w_led'(w_led);

    logic [w_key-1:0] w_press;
    logic [w_key-1:0] w_level;
    logic             w_step;

    for (genvar g = 0; g < w_key; g++) begin : g_key
        key_debounce #(
            .debounce_cycles (debounce_cycles)
        ) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .i_key   (key[g]),
            .o_level (w_level[g]),
            .o_press (w_press[g])
        );
    end

    // Not every channel's level/pulse has a consumer in every build.
    logic w_unused;
    assign w_unused = ^{w_level, w_press, (auto_period_cycles > 0)};

`ifdef KEY_LED_SEQ_AUTO_STEP_EN
    localparam int TW = (auto_period_cycles > 1) ? $clog2(auto_period_cycles) : 1;
    localparam logic [TW-1:0] C_T_LAST = TW'(auto_period_cycles - 1);
    localparam logic [TW-1:0] C_T_ONE  = TW'(1);

    logic [TW-1:0] r_timer;
    logic          w_auto_step;

    assign w_auto_step = w_level[KEY_AUTO] && (r_timer == C_T_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer <= '0;
        end else if (!w_level[KEY_AUTO] || w_press[KEY_CLEAR] || w_press[KEY_MODE]
                     || w_auto_step) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + C_T_ONE;
        end
    end

    // A coincident manual and auto step merge into a single step.
    assign w_step = w_press[KEY_STEP] | w_auto_step;
`else
    assign w_step = w_press[KEY_STEP];
`endif

    mode_t            r_mode;
    mode_t            w_mode_next;
    logic [w_led-1:0] r_count;
    logic [w_led-1:0] w_count_next;
    logic [w_led-1:0] r_led;
    logic [w_led-1:0] w_led_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode  <= MODE_TOGGLE;
            r_count <= '0;
            r_led   <= '0;
        end else begin
            r_mode  <= w_mode_next;
            r_count <= w_count_next;
            r_led   <= w_led_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        w_mode_next  = r_mode;
        w_count_next = r_count;
        w_led_next   = r_led;

        case (r_mode)
            MODE_TOGGLE, MODE_ONEHOT, MODE_BINARY: begin
                // Priority clear > mode > step; losers in the same cycle are dropped.
                if (w_press[KEY_CLEAR]) begin
                    w_count_next = '0;
                    w_led_next   = '0;
                end else if (w_press[KEY_MODE]) begin
                    w_mode_next  = next_mode(r_mode);
                    w_count_next = '0;
                    w_led_next   = '0;
                end else if (w_step) begin
                    case (r_mode)
                        MODE_TOGGLE: begin
                            w_led_next = '0;
                            w_led_next[N_TOGGLE_LEDS-1:0] = ~r_led[N_TOGGLE_LEDS-1:0];
                        end
                        MODE_ONEHOT: begin
                            // Count runs 0..w_led; 0 shows all LEDs off.
                            w_count_next = (r_count == C_ONEHOT_MAX) ? '0 : r_count + C_ONE;
                            w_led_next   = (w_count_next == '0) ? '0
                                         : C_ONE << (w_count_next - C_ONE);
                        end
                        default: begin
                            w_count_next = r_count + C_ONE;
                            w_led_next   = w_count_next;
                        end
                    endcase
                end
            end
            default: begin
                // Unused encoding: recover to a clean TOGGLE state.
                w_mode_next  = MODE_TOGGLE;
                w_count_next = '0;
                w_led_next   = '0;
            end
        endcase
    end

    assign led   = r_led;
    assign mode  = r_mode;
    assign count = r_count;

endmodule

// File: tb/tb_key_led_sequencer.sv
// -----------------------------------------------------------------------------
// tb_key_led_sequencer
// Directed stimulus drives raw key levels; each stimulus pushes the expected
// {led, mode, count} and the clock cycle it must appear on. A monitor compares
// every change of the DUT outputs against the head of that queue.
// -----------------------------------------------------------------------------
module tb_key_led_sequencer;

    localparam int D   = 4;
    localparam int P   = 10;
    localparam int LAT = 2 + D + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] key = 4'b0000;
    logic [7:0] led;
    logic [1:0] mode;
    logic [7:0] count;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] led;
        logic [1:0] mode;
        logic [7:0] count;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];

    key_led_sequencer #(
        .w_key              (4),
        .w_led              (8),
        .debounce_cycles    (D),
        .auto_period_cycles (P)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .key   (key),
        .led   (led),
        .mode  (mode),
        .count (count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_out(input logic [7:0] e_led, input logic [1:0] e_mode,
                              input logic [7:0] e_cnt, input int at);
        exp_t e;
        e.led   = e_led;
        e.mode  = e_mode;
        e.count = e_cnt;
        e.cyc   = at;
        sb_q.push_back(e);
    endtask

    // Advance n clock edges and land just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clean press of the keys in mask, held well past debounce, then released.
    task automatic press(input logic [3:0] mask, input logic [7:0] e_led,
                         input logic [1:0] e_mode, input logic [7:0] e_cnt);
        tick(1);
        key = key | mask;
        expect_out(e_led, e_mode, e_cnt, cyc + LAT);
        tick(12);
        key = key & ~mask;
        tick(10);
    endtask

    // Monitor: any change of the outputs while out of reset consumes one expectation.
    initial begin
        logic [17:0] prev;
        logic [17:0] cur;
        exp_t        e;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {led, mode, count};
            if (!rst) begin
                prev = cur;
            end else if (cur !== prev) begin
                check("expected_pending", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("led",     led,   e.led);
                    check("mode",    mode,  e.mode);
                    check("count",   count, e.count);
                    check("latency", cyc,   e.cyc);
                end
                prev = cur;
            end
        end
    end

    initial begin
        int t;

        // Reset state
        #12;
        check("rst_led",   led,   8'h00);
        check("rst_mode",  mode,  2'd0);
        check("rst_count", count, 8'h00);
        tick(1);
        rst = 1'b1;
        tick(2);

        // TOGGLE: two clean presses
        press(4'b0001, 8'h07, 2'd0, 8'd0);
        press(4'b0001, 8'h00, 2'd0, 8'd0);

        // Bounce every 2 clk for 20 clk, then stable: exactly one step
        tick(1);
        for (int i = 0; i < 5; i++) begin
            key[0] = 1'b1;
            tick(2);
            key[0] = 1'b0;
            tick(2);
        end
        key[0] = 1'b1;
        expect_out(8'h07, 2'd0, 8'd0, cyc + LAT);
        tick(20);
        key[0] = 1'b0;
        tick(10);
        press(4'b0001, 8'h00, 2'd0, 8'd0);

        // ONEHOT: nine steps walk 01..80 then wrap to 00
        press(4'b0010, 8'h00, 2'd1, 8'd0);
        for (int i = 1; i <= 8; i++) begin
            press(4'b0001, 8'h01 << (i - 1), 2'd1, 8'(i));
        end
        press(4'b0001, 8'h00, 2'd1, 8'd0);

        // BINARY: three steps then clear keeps the mode
        press(4'b0010, 8'h00, 2'd2, 8'd0);
        press(4'b0001, 8'h01, 2'd2, 8'd1);
        press(4'b0001, 8'h02, 2'd2, 8'd2);
        press(4'b0001, 8'h03, 2'd2, 8'd3);
        press(4'b0100, 8'h00, 2'd2, 8'd0);
        press(4'b0010, 8'h00, 2'd0, 8'd0);

        // Mode and step in the same cycle: mode wins, step dropped
        press(4'b0011, 8'h00, 2'd1, 8'd0);

        // Reset mid-debounce with nonzero outputs, key kept held through reset
        press(4'b0001, 8'h01, 2'd1, 8'd1);
        tick(1);
        key[0] = 1'b1;
        tick(3);
        #1 rst = 1'b0;
        #1;
        check("async_rst_led",   led,   8'h00);
        check("async_rst_mode",  mode,  2'd0);
        check("async_rst_count", count, 8'h00);
        tick(2);
        rst = 1'b1;
        expect_out(8'h07, 2'd0, 8'd0, cyc + LAT);
        tick(40);
        key[0] = 1'b0;
        tick(10);

`ifdef KEY_LED_SEQ_AUTO_STEP_EN
        // Auto-step in BINARY: debounced key[3] high ~32 clk -> three steps
        press(4'b0010, 8'h00, 2'd1, 8'd0);
        press(4'b0010, 8'h00, 2'd2, 8'd0);
        tick(1);
        key[3] = 1'b1;
        t = cyc;
        expect_out(8'h01, 2'd2, 8'd1, t + 2 + D + P);
        expect_out(8'h02, 2'd2, 8'd2, t + 2 + D + 2 * P);
        expect_out(8'h03, 2'd2, 8'd3, t + 2 + D + 3 * P);
        tick(32);
        key[3] = 1'b0;
        tick(40);
        check("auto_count_after_release", count, 8'd3);
`else
        // key[3] has no function without the auto-step option
        tick(1);
        key[3] = 1'b1;
        t = cyc;
        tick(32);
        key[3] = 1'b0;
        tick(40);
        check("key3_ignored_led",   led,   8'h07);
        check("key3_ignored_count", count, 8'd0);
        check("key3_ignored_time",  cyc - t, 72);
`endif

        tick(5);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
